// File: rtl/mux4_rr_scheduler.sv
// mux4_rr_scheduler
// Round-robin scheduler that shares one 4:1 single-bit mux channel among four
// serial requesters. Each grant owns the channel for up to BURST_LEN beats.
// When a burst ends, the next winner is loaded on the same edge, so there is
// no idle cycle between bursts.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_in     per-requester channel request (bit i = requester i)
//   data_in    per-requester serial data bit (bit i = requester i)
//   sel_out    mux select of the current or last owner
//   grant_out  one-hot grant, all zero when idle
//   y          registered data bit of the granted requester
//   y_valid    y carries a transferred beat this cycle
//   busy       high while in BURST
//
// State  | Meaning
// IDLE   | no owner; waiting for any request
// BURST  | sel_out owns the channel; beats counted in count
module mux4_rr_scheduler #(
    parameter int BURST_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_in,
    input  logic [3:0] data_in,
    output logic [1:0] sel_out,
    output logic [3:0] grant_out,
    output logic       y,
    output logic       y_valid,
    output logic       busy
);

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [1:0]       last_ptr, last_ptr_n;
    logic [1:0]       sel_n;
    logic [3:0]       grant_n;
    logic             y_n, y_valid_n;
    logic [1:0]       winner;
    logic             burst_end;

    // Search starts at ptr+1 and wraps, so ptr itself is checked last.
    // Iterating from the far end lets the earliest match overwrite later ones.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [3:0] req);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) rr_pick = idx;
        end
    endfunction

    assign winner = rr_pick(last_ptr, req_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            last_ptr  <= 2'd3;
            sel_out   <= 2'b00;
            grant_out <= 4'b0000;
            y         <= 1'b0;
            y_valid   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            last_ptr  <= last_ptr_n;
            sel_out   <= sel_n;
            grant_out <= grant_n;
            y         <= y_n;
            y_valid   <= y_valid_n;
            busy      <= (state_n == BURST);
        end
    end

    always_comb begin
        state_n    = state;
        count_n    = count;
        last_ptr_n = last_ptr;
        sel_n      = sel_out;
        grant_n    = grant_out;
        y_n        = y;
        y_valid_n  = 1'b0;
        burst_end  = 1'b0;

        case (state)
            IDLE: begin
                grant_n = 4'b0000;
                if (req_in != 4'b0000) begin
                    state_n    = BURST;
                    sel_n      = winner;
                    grant_n    = 4'b0001 << winner;
                    last_ptr_n = winner;
                    count_n    = '0;
                end
            end
            BURST: begin
                if (req_in[sel_out]) begin
                    y_n       = data_in[sel_out];
                    y_valid_n = 1'b1;
                    if (count == LAST_BEAT) burst_end = 1'b1;
                    else                    count_n   = count + 1'b1;
                end else begin
                    burst_end = 1'b1;
                end

                if (burst_end) begin
                    count_n = '0;
                    if (req_in != 4'b0000) begin
                        sel_n      = winner;
                        grant_n    = 4'b0001 << winner;
                        last_ptr_n = winner;
                    end else begin
                        state_n = IDLE;
                        grant_n = 4'b0000;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
module tb_mux4_rr_scheduler;

    localparam int BL = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_in;
    logic [3:0] data_in;
    logic [1:0] sel_out;
    logic [3:0] grant_out;
    logic       y;
    logic       y_valid;
    logic       busy;

    mux4_rr_scheduler #(.BURST_LEN(BL), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .data_in(data_in),
        .sel_out(sel_out), .grant_out(grant_out), .y(y),
        .y_valid(y_valid), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] sel;
        logic [3:0] grant;
        logic       y;
        logic       yv;
        logic       busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: owner -1 means no owner.
    int   m_owner;
    int   m_last;
    int   m_beats;
    int   m_sel;
    logic m_y;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 3; m_beats = 0; m_sel = 0; m_y = 1'b0;
    endtask

    function automatic int pick(input int last, input logic [3:0] req);
        for (int k = 1; k <= 4; k++)
            if (req[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] req, input logic [3:0] dat);
        exp_t e;
        bit   done;
        e.yv = 1'b0;
        done = 1'b0;
        if (m_owner < 0) begin
            done = 1'b1;
        end else if (req[m_owner]) begin
            m_y = dat[m_owner];
            e.yv = 1'b1;
            m_beats++;
            done = (m_beats == BL);
        end else begin
            done = 1'b1;
        end
        if (done) begin
            m_owner = pick(m_last, req);
            if (m_owner >= 0) begin
                m_last = m_owner; m_sel = m_owner; m_beats = 0;
            end
        end
        e.sel   = 2'(m_sel);
        e.grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e.y     = m_y;
        e.busy  = (m_owner >= 0);
        exp_q.push_back(e);
    endtask

    task automatic check_reset_outputs();
        check("rst_sel", {2'b00, sel_out}, 4'b0000);
        check("rst_grant", grant_out, 4'b0000);
        check("rst_y", {3'b000, y}, 4'b0000);
        check("rst_y_valid", {3'b000, y_valid}, 4'b0000);
        check("rst_busy", {3'b000, busy}, 4'b0000);
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] dat);
        @(negedge clk);
        req_in = req;
        data_in = dat;
        model_step(req, dat);
    endtask

    // Monitor: every rising edge the DUT presents a new registered output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sel_out", {2'b00, sel_out}, {2'b00, e.sel});
                check("grant_out", grant_out, e.grant);
                check("y_valid", {3'b000, y_valid}, {3'b000, e.yv});
                check("y", {3'b000, y}, {3'b000, e.y});
                check("busy", {3'b000, busy}, {3'b000, e.busy});
            end
        end
    end

    task automatic mid_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        req_in = 4'b0000;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] r;
        int         hold;
        rst_n = 1'b0;
        req_in = 4'b0000;
        data_in = 4'b0000;
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Single requester 0 with toggling data, then drain to idle.
        drive(4'b0001, 4'b0000);
        drive(4'b0001, 4'b0001);
        drive(4'b0001, 4'b0000);
        drive(4'b0001, 4'b0001);
        drive(4'b0001, 4'b0001);
        for (int i = 0; i < 4; i++) drive(4'b0000, 4'($urandom_range(0, 15)));

        // Full load: rotation with no idle gap.
        for (int i = 0; i < 40; i++) drive(4'b1111, 4'($urandom_range(0, 15)));

        // Reset mid-burst, then requester 1 must win (search restarts at 0).
        for (int i = 0; i < 3; i++) drive(4'b0101, 4'($urandom_range(0, 15)));
        mid_reset();
        for (int i = 0; i < 6; i++) drive(4'b0010, 4'($urandom_range(0, 15)));

        // Sole requester re-granted back to back.
        for (int i = 0; i < 12; i++) drive(4'b1000, 4'($urandom_range(0, 15)));

        // Requests changing every cycle: frequent early releases.
        for (int i = 0; i < 300; i++)
            drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        mid_reset();

        // Requests held for random stretches: mix of full and partial bursts.
        for (int i = 0; i < 60; i++) begin
            r = 4'($urandom_range(0, 15));
            hold = $urandom_range(1, 12);
            for (int j = 0; j < hold; j++) drive(r, 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 6; i++) drive(4'b0000, 4'b0000);
        @(negedge clk);
        check("queue_drained", 4'(exp_q.size()), 4'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
